// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle main control FSM. Sequences each instruction
//                through fetch/decode/execute/memory/writeback, emits the
//                datapath enables per state, stalls on mem_ready with a
//                bounded timeout and counts retired instructions.
//  Options     : MC_JUMP_EN - enables the j opcode (000010 -> JUMP state).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int                WAIT_W      = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [5:0] C_OP_R    = 6'b000000;
  localparam logic [5:0] C_OP_LW   = 6'b100011;
  localparam logic [5:0] C_OP_SW   = 6'b101011;
  localparam logic [5:0] C_OP_BEQ  = 6'b000100;
  localparam logic [5:0] C_OP_ANDI = 6'b001100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] C_OP_J    = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ANDI_EX = 4'd9,
    S_ANDI_WB = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  // lw/sw choice is captured in DECODE so MEMADR does not depend on opcode later
  logic               is_lw_q, is_lw_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               mem_wait;

  // State, wait counter, load/store flag and retirement counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      is_lw_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      is_lw_q   <= is_lw_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, per-state datapath controls and memory-wait timeout
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    is_lw_d       = is_lw_q;
    mem_wait      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    mem_timeout   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_wait  = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          C_OP_R:    state_d = S_EXEC;
          C_OP_LW:   begin state_d = S_MEMADR; is_lw_d = 1'b1; end
          C_OP_SW:   begin state_d = S_MEMADR; is_lw_d = 1'b0; end
          C_OP_BEQ:  state_d = S_BRANCH;
          C_OP_ANDI: state_d = S_ANDI_EX;
`ifdef MC_JUMP_EN
          C_OP_J:    state_d = S_JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_lw_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_wait = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_wait  = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_ANDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        aluop     = 2'b11;
        state_d   = S_ANDI_WB;
      end
      S_ANDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Count consecutive stalled cycles; abort to FETCH on the last allowed one
    if (mem_wait && !mem_ready) begin
      if (wait_q == C_WAIT_LAST) begin
        mem_timeout = 1'b1;
        state_d     = S_FETCH;
        wait_d      = '0;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end

    retired_d = retired_q + CNT_W'(instr_done);
    state     = state_q;
    retired   = retired_q;

    // Reset silences every output immediately, not only after the edge
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      aluop         = 2'b00;
      pc_source     = 2'b00;
      instr_done    = 1'b0;
      illegal       = 1'b0;
      mem_timeout   = 1'b0;
      state         = 4'd0;
      retired       = '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the processor datapath. It replaces the single-cycle combinational opcode decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and writeback. Every datapath enable is emitted per state, and the FSM stalls on a memory-ready handshake with a bounded timeout. It sits between the instruction register opcode field and the datapath muxes, register file, ALU control and memory port.

## Interface
Parameters:
- TIMEOUT, 16: consecutive cycles with mem_ready low in a memory-wait state before the access is aborted (≥2).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode (IR[31:26]), sampled in DECODE.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
- alu_src_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- aluop  out  2  00 add, 01 sub, 10 funct-decode, 11 and.
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target.
- state  out  4  current state encoding, debug.
- instr_done  out  1  one-cycle pulse on instruction retirement.
- illegal  out  1  one-cycle pulse, unsupported opcode in DECODE.
- mem_timeout  out  1  one-cycle pulse, memory wait aborted.
- retired  out  CNT_W  count of retired instructions.

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, andi 001100, j 000010 (macro only).
- States and encodings, with asserted outputs (all unlisted outputs are 0):
  - FETCH 0: mem_read, alu_src_b=01, and, gated by mem_ready, ir_write and pc_write. Stays in FETCH until mem_ready, then DECODE.
  - DECODE 1: alu_src_b=11. Next state: R→EXEC, lw/sw→MEMADR, beq→BRANCH, andi→ANDI_EX, j→JUMP. Any other opcode pulses illegal and returns to FETCH.
  - MEMADR 2: alu_src_a, alu_src_b=10. Next: lw→MEMRD, sw→MEMWR.
  - MEMRD 3: mem_read, iord. Waits for mem_ready, then MEMWB.
  - MEMWB 4: reg_write, mem_to_reg. Retires, then FETCH.
  - MEMWR 5: mem_write, iord. Waits for mem_ready, retires on it, then FETCH.
  - EXEC 6: alu_src_a, aluop=10. Next: RWB.
  - RWB 7: reg_write, reg_dst. Retires, then FETCH.
  - BRANCH 8: alu_src_a, aluop=01, pc_write_cond, pc_source=01. Retires, then FETCH.
  - ANDI_EX 9: alu_src_a, alu_src_b=10, aluop=11. Next: ANDI_WB.
  - ANDI_WB 10: reg_write. Retires, then FETCH.
  - JUMP 11: pc_write, pc_source=10. Retires, then FETCH.
- Unused state encodings (12–15) go to FETCH on the next edge with all outputs 0.
- Wait counter counts consecutive cycles with mem_ready low in FETCH, MEMRD or MEMWR.
  - Cleared on any state change and on mem_ready.
  - When the counter equals TIMEOUT-1 with mem_ready low: mem_timeout pulses that cycle, the next state is FETCH, and there is no retirement.
  - A FETCH timeout re-enters FETCH with the counter cleared.
- retired increments on each instr_done and wraps modulo 2^CNT_W.

## Timing
- All outputs are combinational from the registered state. mem_ready gating applies only to ir_write, pc_write (in FETCH), instr_done (in MEMWR) and mem_timeout.
- While rst is high, every output is forced to 0.
- On the first edge with rst high: state=FETCH, wait counter=0, retired=0. FETCH outputs appear in the first cycle after rst falls.
- rst asserted mid-instruction aborts it: no retirement, no write pulse after the reset edge.
- Cycle counts with mem_ready held high: R 4, lw 5, sw 4, beq 3, andi 4, j 3, illegal 2.
- Each stalled memory cycle adds 1 to the count.

## Configuration
- MC_JUMP_EN defined: opcode 000010 decodes to JUMP (state 11). pc_source=10 is reachable.
- MC_JUMP_EN undefined: 000010 is illegal. State 11 is treated as unused. pc_source never drives 10.

## Test plan
- Reset, then R-format (000000) with mem_ready=1: state sequence 0,1,6,7. reg_write and reg_dst are 1 only in cycle 4. instr_done pulses once. retired=1.
- lw (100011) with mem_ready low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,4 (8 cycles). mem_to_reg=1 in state 4 only.
- sw then beq back-to-back, mem_ready=1: sw 4 cycles with mem_write only in state 5, then beq 3 cycles with pc_write_cond=1 and aluop=01 in state 8. retired=2.
- TIMEOUT=4, mem_ready held low in MEMWR: mem_timeout pulses in the 4th wait cycle, next state=0, no instr_done, retired unchanged.
- Opcode 111111, and opcode 000010 with MC_JUMP_EN undefined: illegal pulses in DECODE, returns to FETCH, no write enables. With MC_JUMP_EN: sequence 0,1,11, pc_write=1, pc_source=10.
- rst asserted in MEMWB: next cycle all outputs 0, and after release state=0 and retired=0.
